ps2_keypad: RTL and testbench
=============================

PS2_KEYPAD -- requirements
Module: ps2_keypad

Interface
REQ-001 clk  input  1  system clock, 27 MHz; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ps2_clk  input  1  PS/2 keyboard clock, asynchronous, open-collector idle-high.
REQ-004 ps2_data  input  1  PS/2 keyboard data, asynchronous.
REQ-005 col  input  5  keypad column select, driven by CPU address bits [4:0].
REQ-006 halt_mode  input  1  1 = halt_sw toggles per F11 press; 0 = halt_sw follows F11 level.
REQ-007 row  output  8  active-low row bits of the selected column (0 = key down).
REQ-008 halt_sw  output  1  halt switch state.
REQ-009 init_sw  output  1  init (CPU reset) switch, high while F12 held.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; the sampled ps2_clk SHALL be accepted only after 8 consecutive equal samples (glitch filter).
REQ-011 A data bit SHALL be sampled on each filtered ps2_clk falling edge; frame = start(0), 8 data bits LSB first, odd parity, stop(1): 11 bits.
REQ-012 A frame with start=1, stop=0 or even parity SHALL be discarded with no state change.
REQ-013 If no falling edge arrives for 2^17 clk cycles mid-frame, the bit counter SHALL return to 0 (frame abandoned).
REQ-014 A valid byte SHALL be processed in the cycle after the stop bit; matrix/switch updates visible on outputs 1 cycle later.
REQ-015 Byte 0xE0 SHALL set an extended flag; byte 0xF0 SHALL set a break flag; neither alters the matrix.
REQ-016 Any other byte SHALL clear both flags after use; if the extended flag was set, the byte SHALL be ignored (no extended keys mapped).
REQ-017 Make (break flag clear) SHALL set the mapped key bit pressed; break SHALL release it; repeats of a make are idempotent.
REQ-018 Set-2 hex key map, value k -> column k/8, row bit k%8: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46 A=1C B=32 C=21 D=23 E=24 F=2B.
REQ-019 Command keys, column 2: Enter 5A -> bit0, Backspace 66 -> bit1, Space 29 -> bit2, Tab 0D -> bit3; column 2 bits 7:4 always released.
REQ-020 row SHALL be combinational from col and the 24-bit matrix register; col >= 3 SHALL give 8'hFF.
REQ-021 Multiple simultaneous keys SHALL be held independently; all in the same column appear together in row.
REQ-022 F12 (07): make -> init_sw=1, break -> init_sw=0.
REQ-023 F11 (78), halt_mode=0: halt_sw = 1 on make, 0 on break.
REQ-024 F11, halt_mode=1: halt_sw inverts on each make (auto-repeat makes while held do not re-toggle, tracked by an F11-held flag); break only clears the held flag.
REQ-025 Unmapped non-prefix codes SHALL only clear the flags.

Reset
REQ-026 On reset: all keys released (row=8'hFF for any col), halt_sw=0, init_sw=0, E0/F0/F11-held flags 0, bit counter 0, timeout counter 0, filter state idle-high.
REQ-027 Reset mid-frame SHALL abandon the frame; the next valid frame after reset SHALL decode normally.

Structure
REQ-028 Package keypad_pkg SHALL hold scan-code constants (prefixes, hex, command, F11/F12), NUM_COLS=3, timeout width 17.
REQ-029 One sub-module ps2_rx (synchronizer, filter, shift register, parity/timeout, byte + valid strobe); key mapping and switches in ps2_keypad.

Verification
REQ-030 Send 0x16 (key 1), col=0 -> row=8'hFD; send F0,16 -> row=8'hFF.
REQ-031 Send 0x2B (F) and 0x5A (Enter) -> col=1 row=8'h7F, col=2 row=8'hFE, col=5 row=8'hFF.
REQ-032 Send 0x16 with parity bit flipped -> row for col=0 stays 8'hFF.
REQ-033 halt_mode=1: send 78,78,F0,78,78 -> halt_sw 0->1 (second make ignored), then 1->0 on final make; halt_mode=0: 78 -> 1, F0 78 -> 0.
REQ-034 Send E0,45 -> col=0 stays 8'hFF; send 07 -> init_sw=1; assert reset -> init_sw=0, row=8'hFF.
REQ-035 Send 5 bits of a frame, idle 2^17+10 cycles, send full 0x45 -> col=0 row=8'hFE.

Source files
------------

// File: rtl/ps2_keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared constants and helpers for the PS/2 keyboard to keypad-matrix bridge.
//   - PS/2 set-2 scan codes: prefixes (E0/F0), hex keys 0-F, command keys,
//     and the two switch keys (F11 = halt, F12 = init).
//   - Matrix geometry: NUM_COLS columns of 8 row bits each.
//   - Receiver timeout width: a frame is abandoned after 2^PS2_TIMEOUT_W
//     clk cycles without a PS/2 clock falling edge.
//   - map_key(): translates a scan code to a matrix bit index.
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int NUM_COLS      = 3;
    localparam int MATRIX_W      = NUM_COLS * 8;
    localparam int PS2_TIMEOUT_W = 17;

    // Prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Switch keys
    localparam logic [7:0] SC_F11 = 8'h78;
    localparam logic [7:0] SC_F12 = 8'h07;

    // Command keys (column 2, bits 0..3)
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_TAB   = 8'h0D;

    // Hex keys: SC_HEX[k] is the scan code of hex digit k
    localparam logic [7:0] SC_HEX [16] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
    };

    // Matrix bit index of the first command key (column 2, row bit 0)
    localparam logic [4:0] CMD_BASE = 5'd16;

    // Result of a scan-code lookup: hit=1 when the code owns a matrix bit
    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_map_t;

    // Matrix bit index = column*8 + row bit.
    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b0;
        m.idx = '0;
        for (int k = 0; k < 16; k++) begin
            if (code == SC_HEX[k]) begin
                m.hit = 1'b1;
                m.idx = 5'(k);
            end
        end
        case (code)
            SC_ENTER: begin m.hit = 1'b1; m.idx = CMD_BASE + 5'd0; end
            SC_BKSP:  begin m.hit = 1'b1; m.idx = CMD_BASE + 5'd1; end
            SC_SPACE: begin m.hit = 1'b1; m.idx = CMD_BASE + 5'd2; end
            SC_TAB:   begin m.hit = 1'b1; m.idx = CMD_BASE + 5'd3; end
            default:  ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// -----------------------------------------------------------------------------
// ps2_keypad_if
// Bundles the keyboard lines, the CPU-side keypad scan port and the switch
// outputs of the PS/2 keypad bridge.
//   ps2_clk   : PS/2 clock, asynchronous, idle high
//   ps2_data  : PS/2 data, asynchronous
//   col[4:0]  : keypad column select from CPU address bits
//   halt_mode : 1 = halt_sw toggles per F11 press, 0 = follows F11 level
//   row[7:0]  : active-low row bits of the selected column
//   halt_sw   : halt switch state
//   init_sw   : init switch, high while F12 held
// master = keyboard/CPU side (drives inputs), slave = the bridge.
// -----------------------------------------------------------------------------
interface ps2_keypad_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] col;
    logic       halt_mode;
    logic [7:0] row;
    logic       halt_sw;
    logic       init_sw;

    modport master (
        output ps2_clk, ps2_data, col, halt_mode,
        input  row, halt_sw, init_sw
    );

    modport slave (
        input  ps2_clk, ps2_data, col, halt_mode,
        output row, halt_sw, init_sw
    );

endinterface

// File: rtl/ps2_keypad_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 serial receiver. Synchronizes the keyboard lines, deglitches the PS/2
// clock, shifts in 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and emits each correctly framed byte with a one-cycle strobe.
//   clk       : system clock (27 MHz), rising edge
//   reset     : synchronous, active-high
//   ps2_clk   : raw PS/2 clock
//   ps2_data  : raw PS/2 data
//   rx_byte   : last accepted data byte
//   rx_valid  : one-cycle strobe, the cycle after the stop bit was sampled
// Parameter TIMEOUT_W: a partial frame is dropped after 2^TIMEOUT_W cycles
// without a PS/2 clock falling edge.
// -----------------------------------------------------------------------------
module ps2_rx
    import keypad_pkg::*;
#(
    parameter int TIMEOUT_W = PS2_TIMEOUT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    logic [1:0]           clk_sync;
    logic [1:0]           data_sync;
    logic [7:0]           filt_hist;
    logic                 filt_clk;
    logic                 fall;
    logic [3:0]           bit_cnt;
    logic [9:0]           shift;
    logic [10:0]          frame;
    logic                 frame_ok;
    logic [TIMEOUT_W-1:0] idle_cnt;

    // Two-flop synchronizers; reset to the idle-high line level so no false
    // edge is seen when reset is released.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock only changes after 8 equal samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_hist <= 8'hFF;
            filt_clk  <= 1'b1;
        end else begin
            filt_hist <= {filt_hist[6:0], clk_sync[1]};
            if (filt_hist == 8'hFF)
                filt_clk <= 1'b1;
            else if (filt_hist == 8'h00)
                filt_clk <= 1'b0;
        end
    end

    // Single-cycle pulse in the cycle the filtered clock is about to fall.
    assign fall = filt_clk && (filt_hist == 8'h00);

    // shift holds bits 0..9 once ten bits are in (shift[0] = start bit);
    // the stop bit is taken straight from the line when it arrives.
    assign frame    = {data_sync[1], shift};
    assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            idle_cnt <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        rx_byte  <= frame[8:1];
                        rx_valid <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {data_sync[1], shift[9:1]};
                end
            end else if (bit_cnt != '0) begin
                // Mid-frame and the keyboard went quiet: give up on the frame.
                if (&idle_cnt) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keypad.sv
// -----------------------------------------------------------------------------
// ps2_keypad
// Presents a PS/2 keyboard to the CPU as a 3-column x 8-row hex keypad matrix
// plus halt and init switches.
//   clk    : system clock (27 MHz), rising edge
//   reset  : synchronous, active-high
//   kp     : ps2_keypad_if.slave -- PS/2 lines, col select, halt_mode in;
//            row (active-low), halt_sw, init_sw out
// Column 0 = hex 0-7, column 1 = hex 8-F, column 2 = Enter/Backspace/Space/Tab
// on bits 0..3. F12 drives init_sw, F11 drives halt_sw (level or toggle).
// Parameter TIMEOUT_W is passed to the receiver's frame timeout.
// -----------------------------------------------------------------------------
module ps2_keypad
    import keypad_pkg::*;
#(
    parameter int TIMEOUT_W = PS2_TIMEOUT_W
) (
    input  logic    clk,
    input  logic    reset,
    ps2_keypad_if.slave kp
);

    logic [7:0]          rx_byte;
    logic                rx_valid;
    key_map_t            key;
    logic [MATRIX_W-1:0] matrix;      // 1 = key held
    logic                ext_flag;
    logic                brk_flag;
    logic                f11_held;
    logic                halt_q;
    logic                init_q;
    logic [7:0]          row_c;

    ps2_rx #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (kp.ps2_clk),
        .ps2_data (kp.ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    assign key = map_key(rx_byte);

    // Byte decoder. Prefixes only set flags; any other byte consumes and
    // clears both. Extended codes are dropped because none are mapped.
    // NOTE: the 24-bit matrix is a plain register, not a memory, so it is
    // reset directly; all keys must read released after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            matrix   <= '0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            f11_held <= 1'b0;
            halt_q   <= 1'b0;
            init_q   <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_flag <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                if (!ext_flag) begin
                    if (key.hit) begin
                        matrix[key.idx] <= !brk_flag;
                    end else if (rx_byte == SC_F12) begin
                        init_q <= !brk_flag;
                    end else if (rx_byte == SC_F11) begin
                        if (kp.halt_mode) begin
                            // Toggle once per physical press; typematic
                            // repeats arrive as extra makes while held.
                            if (brk_flag) begin
                                f11_held <= 1'b0;
                            end else begin
                                if (!f11_held)
                                    halt_q <= !halt_q;
                                f11_held <= 1'b1;
                            end
                        end else begin
                            halt_q   <= !brk_flag;
                            f11_held <= !brk_flag;
                        end
                    end
                end
            end
        end
    end

    // Column read-out; unused columns read all released.
    // NOTE: row_c gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        row_c = 8'hFF;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (kp.col == c[4:0])
                row_c = ~matrix[c*8 +: 8];
        end
    end

    assign kp.row     = row_c;
    assign kp.halt_sw = halt_q;
    assign kp.init_sw = init_q;

endmodule

// File: tb/tb_ps2_keypad.sv
`timescale 1ns/1ps
module tb_ps2_keypad;

    localparam int TW   = 10;  // reduced frame timeout for simulation
    localparam int HALF = 24;  // PS/2 half bit period in clk cycles

    typedef struct packed {
        logic [4:0] col;
        logic [7:0] row;
        logic       halt;
        logic       init;
    } exp_t;

    logic clk;
    logic reset;
    exp_t  exp_q[$];
    string tag_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    logic  exp_halt    = 1'b0;
    logic  exp_init    = 1'b0;

    ps2_keypad_if kp_if();

    ps2_keypad #(
        .TIMEOUT_W (TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    initial clk = 1'b0;
    always #18 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            kp_if.ps2_data = f[i];
            tick(HALF);
            kp_if.ps2_clk = 1'b0;
            tick(HALF);
            kp_if.ps2_clk = 1'b1;
        end
        kp_if.ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
        tick(HALF);
    endtask

    task automatic expect_row(input string tag, input logic [4:0] c, input logic [7:0] r);
        exp_t e;
        e.col  = c;
        e.row  = r;
        e.halt = exp_halt;
        e.init = exp_init;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            kp_if.col = e.col;
            @(negedge clk);
            vectors++;
            assert (kp_if.row === e.row) else begin
                miscompares++;
                $error("FAIL %s row: got %h expected %h", t, kp_if.row, e.row);
            end
            vectors++;
            assert (kp_if.halt_sw === e.halt) else begin
                miscompares++;
                $error("FAIL %s halt_sw: got %b expected %b", t, kp_if.halt_sw, e.halt);
            end
            vectors++;
            assert (kp_if.init_sw === e.init) else begin
                miscompares++;
                $error("FAIL %s init_sw: got %b expected %b", t, kp_if.init_sw, e.init);
            end
        end
    endtask

    initial begin
        kp_if.ps2_clk   = 1'b1;
        kp_if.ps2_data  = 1'b1;
        kp_if.col       = 5'd0;
        kp_if.halt_mode = 1'b0;
        reset = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(5);

        // Reset state
        expect_row("rst_c0", 5'd0, 8'hFF);
        expect_row("rst_c1", 5'd1, 8'hFF);
        expect_row("rst_c2", 5'd2, 8'hFF);
        expect_row("rst_c31", 5'd31, 8'hFF);
        drain();

        // Key 1 make / break
        send(8'h16);
        expect_row("key1_make", 5'd0, 8'hFD);
        drain();
        send(8'hF0); send(8'h16);
        expect_row("key1_break", 5'd0, 8'hFF);
        drain();

        // F and Enter, out-of-range column
        send(8'h2B); send(8'h5A);
        expect_row("keyF", 5'd1, 8'h7F);
        expect_row("enter", 5'd2, 8'hFE);
        expect_row("col5", 5'd5, 8'hFF);
        drain();

        // Multiple keys in one column, idempotent repeat, more command keys
        send(8'h16); send(8'h45);
        expect_row("multi_c0", 5'd0, 8'hFC);
        drain();
        send(8'h16);
        expect_row("repeat", 5'd0, 8'hFC);
        send(8'h29); send(8'h0D);
        expect_row("cmd_c2", 5'd2, 8'hF2);
        drain();
        send(8'hF0); send(8'h5A); send(8'h66);
        expect_row("bksp", 5'd2, 8'hF1);
        drain();

        // Release everything
        send(8'hF0); send(8'h16); send(8'hF0); send(8'h45);
        send(8'hF0); send(8'h2B); send(8'hF0); send(8'h66);
        send(8'hF0); send(8'h29); send(8'hF0); send(8'h0D);
        expect_row("rel_c0", 5'd0, 8'hFF);
        expect_row("rel_c1", 5'd1, 8'hFF);
        expect_row("rel_c2", 5'd2, 8'hFF);
        drain();

        // Unmapped code clears the break flag, so the next key is a make
        send(8'hF0); send(8'h1A); send(8'h16);
        expect_row("unmapped", 5'd0, 8'hFD);
        drain();
        send(8'hF0); send(8'h16);

        // Malformed frames are discarded
        send_bits(mk_frame(8'h16, 1'b1), 11); tick(HALF);
        expect_row("bad_parity", 5'd0, 8'hFF);
        drain();
        send_bits(mk_frame(8'h16, 1'b0) & 11'h3FF, 11); tick(HALF);
        expect_row("bad_stop", 5'd0, 8'hFF);
        drain();
        send_bits(mk_frame(8'h16, 1'b0) | 11'h001, 11); tick(HALF);
        expect_row("bad_start", 5'd0, 8'hFF);
        drain();
        send(8'h16);
        expect_row("resync", 5'd0, 8'hFD);
        drain();
        send(8'hF0); send(8'h16);

        // F11 in toggle mode
        kp_if.halt_mode = 1'b1;
        send(8'h78);
        exp_halt = 1'b1;
        expect_row("f11_t_make", 5'd0, 8'hFF);
        drain();
        send(8'h78);
        expect_row("f11_t_repeat", 5'd0, 8'hFF);
        drain();
        send(8'hF0); send(8'h78);
        expect_row("f11_t_break", 5'd0, 8'hFF);
        drain();
        send(8'h78);
        exp_halt = 1'b0;
        expect_row("f11_t_make2", 5'd0, 8'hFF);
        drain();
        send(8'hF0); send(8'h78);

        // F11 in level mode
        kp_if.halt_mode = 1'b0;
        send(8'h78);
        exp_halt = 1'b1;
        expect_row("f11_l_make", 5'd0, 8'hFF);
        drain();
        send(8'hF0); send(8'h78);
        exp_halt = 1'b0;
        expect_row("f11_l_break", 5'd0, 8'hFF);
        drain();

        // Extended prefix ignored; F12 init; reset clears everything
        send(8'hE0); send(8'h45);
        expect_row("ext_45", 5'd0, 8'hFF);
        drain();
        send(8'h07);
        exp_init = 1'b1;
        expect_row("f12_make", 5'd0, 8'hFF);
        drain();
        send(8'h45);
        expect_row("key0_after_ext", 5'd0, 8'hFE);
        drain();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        exp_init = 1'b0;
        expect_row("post_rst_c0", 5'd0, 8'hFF);
        drain();

        // Partial frame abandoned by the timeout
        send_bits(mk_frame(8'h45, 1'b0), 5);
        tick((1 << TW) + 10);
        send(8'h45);
        expect_row("timeout", 5'd0, 8'hFE);
        drain();

        // Reset mid-frame abandons it
        send_bits(mk_frame(8'h16, 1'b0), 4);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        send(8'h16);
        expect_row("rst_midframe", 5'd0, 8'hFD);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
